// File: rtl/lag_correlator_pkg.sv
// lag_correlator_pkg
// Shared definitions for the multi-lag pulse correlator.
//   num_correlators(n)    : number of unordered input pairs
//   num_words(n, lags)    : length of one readout stream
//   pair_index(a, b, n)   : linear index of pair (a,b), a<b, in lexicographic order
//   state_t               : readout FSM states
package lag_correlator_pkg;

    typedef enum logic {
        IDLE,
        READOUT
    } state_t;

    function automatic int num_correlators(int n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int num_words(int n, int lags);
        return num_correlators(n) * lags + n;
    endfunction

    function automatic int pair_index(int a, int b, int n);
        return a * (2 * n - a - 1) / 2 + b - a - 1;
    endfunction

endpackage

// File: rtl/lag_correlator_delay_ring.sv
// lag_correlator_delay_ring
// Programmable delay for one pulse input: a 2^DELAY_BITS x 1 ring written every
// cycle at the shared write pointer, read at wr_ptr - delay, masked until the
// ring holds enough post-reset history, and registered into the s1 stage.
//   clk, rst_n : clock, synchronous active-low reset (clears only the s1 register)
//   din        : s0-registered pulse level for this input
//   wr_ptr     : shared ring write pointer
//   fill       : number of ring writes since reset, saturating at 2^DELAY_BITS
//   delay      : programmed delay in cycles
//   tap        : delayed, masked pulse level (stage s1)
module lag_correlator_delay_ring #(
    parameter int DELAY_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic [DELAY_BITS-1:0] wr_ptr,
    input  logic [DELAY_BITS:0]   fill,
    input  logic [DELAY_BITS-1:0] delay,
    output logic                  tap
);

    localparam int DEPTH = 2 ** DELAY_BITS;

    logic                  mem [DEPTH];
    logic [DELAY_BITS-1:0] rd_addr;
    logic                  raw;
    logic                  masked;

    assign rd_addr = wr_ptr - delay;

    // A zero delay must see the value being written this cycle, which is not
    // in the RAM yet, so it bypasses straight from din.
    always_comb begin
        raw    = (delay == '0) ? din : mem[rd_addr];
        masked = ({1'b0, delay} >= fill) ? 1'b0 : raw;
    end

    // Ring contents are deliberately not reset; fill masking hides stale entries.
    always_ff @(posedge clk) begin
        mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap <= 1'b0;
        end else begin
            tap <= masked;
        end
    end

endmodule

// File: rtl/lag_correlator.sv
// lag_correlator
// Counts per-input pulses and pairwise coincidences at LAGS relative lags over
// integration windows, then streams the finished window over valid/ready.
//   clk, rst_n          : clock, synchronous active-low reset
//   pulse_in            : pulse levels, one per input
//   integration_tick    : one-cycle window-end strobe
//   cfg_valid/index/delay : per-input delay write
//   rd_valid/ready/data/last : snapshot word stream, WORDS words per window
//   overrun             : sticky, set when a tick is dropped during readout
//
// Readout FSM
//   state   | meaning
//   IDLE    | no snapshot pending, rd_valid low
//   READOUT | streaming snapshot[idx], advance on rd_valid & rd_ready
module lag_correlator #(
    parameter int NUM_INPUTS = 4,
    parameter int RESOLUTION = 16,
    parameter int LAGS       = 5,
    parameter int DELAY_BITS = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_INPUTS-1:0]         pulse_in,
    input  logic                          integration_tick,
    input  logic                          cfg_valid,
    input  logic [$clog2(NUM_INPUTS)-1:0] cfg_index,
    input  logic [DELAY_BITS-1:0]         cfg_delay,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [RESOLUTION-1:0]         rd_data,
    output logic                          rd_last,
    output logic                          overrun
);

    import lag_correlator_pkg::*;

    localparam int NUM_CORRELATORS = num_correlators(NUM_INPUTS);
    localparam int WORDS           = num_words(NUM_INPUTS, LAGS);
    localparam int IDX_W           = $clog2(WORDS);
    localparam int CFG_W           = $clog2(NUM_INPUTS);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [DELAY_BITS:0] FILL_FULL = {1'b1, {DELAY_BITS{1'b0}}};

    logic [NUM_INPUTS-1:0] s0_q;
    logic [DELAY_BITS-1:0] wr_ptr_q;
    logic [DELAY_BITS:0]   fill_q;
    logic [NUM_INPUTS-1:0] tap;
    logic [LAGS-1:0]       y [NUM_INPUTS];
    logic [WORDS-1:0]      inc;
    logic [RESOLUTION-1:0] snap_words [WORDS];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overrun_q, overrun_d;
    logic             last_xfer;
    logic             take_snapshot;

    // ---------------- input stage, shared ring pointer, fill counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_q     <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            s0_q     <= pulse_in;
            wr_ptr_q <= wr_ptr_q + DELAY_BITS'(1);
            if (fill_q != FILL_FULL) begin
                fill_q <= fill_q + (DELAY_BITS + 1)'(1);
            end
        end
    end

    // ---------------- per-input delay register, ring and lag line
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        logic [DELAY_BITS-1:0] delay_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                delay_q <= '0;
            end else if (cfg_valid && (cfg_index == CFG_W'(i))) begin
                delay_q <= cfg_delay;
            end
        end

        lag_correlator_delay_ring #(
            .DELAY_BITS(DELAY_BITS)
        ) u_ring (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (s0_q[i]),
            .wr_ptr (wr_ptr_q),
            .fill   (fill_q),
            .delay  (delay_q),
            .tap    (tap[i])
        );

        // y[i][k] is the delayed stream k cycles ago; tap k=0 is s1 itself.
        if (LAGS == 1) begin : g_nolag
            assign y[i] = tap[i];
        end else begin : g_lag
            logic [LAGS-2:0] lag_q;
            assign y[i] = {lag_q, tap[i]};
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lag_q <= '0;
                end else begin
                    lag_q <= y[i][LAGS-2:0];
                end
            end
        end

        assign inc[NUM_CORRELATORS * LAGS + i] = tap[i];
    end

    // ---------------- coincidence increments
    // Tap l of a is paired with tap LAGS-1-l of b, so the centre tap is zero lag.
    for (genvar a = 0; a < NUM_INPUTS; a++) begin : g_a
        for (genvar b = a + 1; b < NUM_INPUTS; b++) begin : g_b
            for (genvar l = 0; l < LAGS; l++) begin : g_l
                assign inc[pair_index(a, b, NUM_INPUTS) * LAGS + l] = y[a][l] & y[b][LAGS-1-l];
            end
        end
    end

    // ---------------- saturating counters and snapshot
    // The increment of the tick cycle belongs to the closing window.
    for (genvar w = 0; w < WORDS; w++) begin : g_word
        logic [RESOLUTION-1:0] cnt_q;
        logic [RESOLUTION-1:0] snap_q;
        logic [RESOLUTION-1:0] cnt_next;

        assign cnt_next = (inc[w] && (cnt_q != '1)) ? cnt_q + RESOLUTION'(1) : cnt_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                snap_q <= '0;
            end else begin
                cnt_q <= integration_tick ? '0 : cnt_next;
                if (take_snapshot) begin
                    snap_q <= cnt_next;
                end
            end
        end

        assign snap_words[w] = snap_q;
    end

    // ---------------- readout FSM
    assign last_xfer     = (state_q == READOUT) && rd_ready && (idx_q == LAST_IDX);
    assign take_snapshot = integration_tick && ((state_q == IDLE) || last_xfer);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (integration_tick) begin
                    state_d = READOUT;
                    idx_d   = '0;
                end
            end
            READOUT: begin
                // A tick landing on the final transfer starts the next stream
                // seamlessly; any other tick here loses its window.
                if (integration_tick && !last_xfer) begin
                    overrun_d = 1'b1;
                end
                if (rd_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = integration_tick ? READOUT : IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        rd_valid = (state_q == READOUT);
        rd_last  = (state_q == READOUT) && (idx_q == LAST_IDX);
        rd_data  = (state_q == READOUT) ? snap_words[idx_q] : '0;
        overrun  = overrun_q;
    end

endmodule

// File: tb/tb_lag_correlator.sv
// tb_lag_correlator
// Directed sequence with random pulse traffic for lag_correlator, checked each
// cycle against a window/queue reference model of the correlator behaviour.
module tb_lag_correlator;

    localparam int N   = 4;
    localparam int R   = 16;
    localparam int L   = 5;
    localparam int DB  = 10;
    localparam int NP  = N * (N - 1) / 2;
    localparam int NW  = NP * L + N;
    localparam int MAXC = (1 << R) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  pulse_in = '0;
    logic          integration_tick = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [1:0]    cfg_index = '0;
    logic [DB-1:0] cfg_delay = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic [R-1:0]  rd_data;
    logic          rd_last;
    logic          overrun;

    always #5 clk = ~clk;

    lag_correlator #(
        .NUM_INPUTS (N),
        .RESOLUTION (R),
        .LAGS       (L),
        .DELAY_BITS (DB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pulse_in         (pulse_in),
        .integration_tick (integration_tick),
        .cfg_valid        (cfg_valid),
        .cfg_index        (cfg_index),
        .cfg_delay        (cfg_delay),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_data          (rd_data),
        .rd_last          (rd_last),
        .overrun          (overrun)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int           m_cnt [NW];
    int           q [$];
    bit           m_ovr;
    int           m_dly [N];
    bit           xv [N][L];
    logic [N-1:0] ph [2048];
    int           m;

    int got [NW];
    int gi;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // One clock edge of the reference, using the inputs as driven before it.
    function automatic void model_edge();
        int inc [NW];
        int p;
        int src;
        bit xfer, lastx, acc;
        bit nx [N];
        if (!rst_n) begin
            for (int w = 0; w < NW; w++) m_cnt[w] = 0;
            q.delete();
            m_ovr = 0;
            m = 0;
            for (int i = 0; i < N; i++) begin
                m_dly[i] = 0;
                for (int k = 0; k < L; k++) xv[i][k] = 0;
            end
            return;
        end
        p = 0;
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++) begin
                for (int l = 0; l < L; l++) inc[p * L + l] = int'(xv[a][l] & xv[b][L-1-l]);
                p++;
            end
        for (int i = 0; i < N; i++) inc[NP * L + i] = int'(xv[i][0]);

        xfer  = (q.size() > 0) && rd_ready;
        lastx = xfer && (q.size() == 1);
        acc   = integration_tick && ((q.size() == 0) || lastx);
        if (integration_tick && !acc) m_ovr = 1;
        if (xfer) void'(q.pop_front());
        if (acc) for (int w = 0; w < NW; w++) q.push_back(sat(m_cnt[w] + inc[w]));
        for (int w = 0; w < NW; w++) m_cnt[w] = integration_tick ? 0 : sat(m_cnt[w] + inc[w]);

        // delayed stream: pulse sampled 1+delay edges before this one, zero if before reset
        for (int i = 0; i < N; i++) begin
            src = m - 1 - m_dly[i];
            nx[i] = (src >= 0) ? ph[src % 2048][i] : 1'b0;
            for (int k = L - 1; k > 0; k--) xv[i][k] = xv[i][k-1];
            xv[i][0] = nx[i];
        end
        ph[m % 2048] = pulse_in;
        if (cfg_valid) m_dly[cfg_index] = int'(cfg_delay);
        m++;
    endfunction

    task automatic step();
        if (rd_valid && rd_ready && gi < NW) begin
            got[gi] = int'(rd_data);
            gi++;
        end
        model_edge();
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
        chk("rd_data", 32'(rd_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk("rd_last", 32'(rd_last), 32'(q.size() == 1));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic run(int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic tick();
        integration_tick = 1'b1;
        step();
        integration_tick = 1'b0;
    endtask

    task automatic cfg_write(int idx, int d);
        cfg_valid = 1'b1;
        cfg_index = 2'(idx);
        cfg_delay = DB'(d);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        rd_ready = 1'b1;
        while (rd_valid && c < 300) begin
            step();
            c++;
        end
        chk("drain_done", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        gi = 0;
        // reset
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(2);
        chk("reset_valid", 32'(rd_valid), 32'd0);
        chk("reset_data", 32'(rd_data), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);

        // idle inputs, periodic ticks: all-zero streams of NW words
        rd_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            gi = 0;
            tick();
            chk("tick_latency", 32'(rd_valid), 32'd1);
            run(99);
            chk("zero_stream_len", 32'(gi), 32'(NW));
            for (int w = 0; w < NW; w++) chk("zero_stream_word", 32'(got[w]), 32'd0);
        end

        // inputs 0 and 1 high together for 50 cycles
        tick();
        drain();
        pulse_in = 4'b0011;
        run(50);
        pulse_in = '0;
        run(10);
        gi = 0;
        tick();
        drain();
        chk("pair01_centre", 32'(got[2]), 32'd50);
        chk("input0_count", 32'(got[NP * L]), 32'd50);
        chk("input1_count", 32'(got[NP * L + 1]), 32'd50);

        // delay 3 on input 1 aligns a pulse on 1 with one on 0 three cycles later
        cfg_write(1, 3);
        run(5);
        tick();
        drain();
        pulse_in = 4'b0010;
        step();
        pulse_in = '0;
        run(2);
        pulse_in = 4'b0001;
        step();
        pulse_in = '0;
        run(20);
        gi = 0;
        tick();
        drain();
        chk("delay_centre", 32'(got[2]), 32'd1);
        chk("delay_lag0", 32'(got[0]), 32'd0);
        chk("delay_lag1", 32'(got[1]), 32'd0);
        chk("delay_lag3", 32'(got[3]), 32'd0);
        chk("delay_lag4", 32'(got[4]), 32'd0);
        cfg_write(1, 0);

        // saturation
        tick();
        drain();
        pulse_in = '1;
        run(66000);
        pulse_in = '0;
        gi = 0;
        tick();
        drain();
        for (int w = 0; w < NW; w++) chk("saturated_word", 32'(got[w]), 32'(MAXC));

        // overrun: second tick while the first stream is held
        for (int c = 0; c < 60; c++) begin
            pulse_in = N'($urandom);
            step();
        end
        rd_ready = 1'b0;
        tick();
        for (int c = 0; c < 30; c++) begin
            pulse_in = N'($urandom);
            step();
        end
        chk("overrun_clear_before", 32'(overrun), 32'd0);
        tick();
        chk("overrun_set", 32'(overrun), 32'd1);
        for (int c = 0; c < 20; c++) begin
            pulse_in = N'($urandom);
            step();
        end
        gi = 0;
        begin
            int c;
            c = 0;
            while (rd_valid && c < 500) begin
                rd_ready = 1'($urandom_range(0, 1));
                pulse_in = N'($urandom);
                step();
                c++;
            end
        end
        chk("overrun_stream_len", 32'(gi), 32'(NW));
        pulse_in = '0;
        run(10);
        tick();
        drain();

        // reset in the middle of a stream
        run(5);
        gi = 0;
        tick();
        begin
            int c;
            c = 0;
            while (gi < 10 && c < 100) begin
                step();
                c++;
            end
        end
        chk("reached_word10", 32'(gi), 32'd10);
        rst_n = 1'b0;
        step();
        chk("reset_mid_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        run(5);
        gi = 0;
        tick();
        drain();
        chk("fresh_stream_len", 32'(gi), 32'(NW));
        for (int w = 0; w < NW; w++) chk("fresh_stream_word", 32'(got[w]), 32'd0);

        // random traffic with long delays while the ring is still filling
        cfg_write(2, 600);
        cfg_write(3, 1023);
        cfg_write(1, 7);
        for (int win = 0; win < 5; win++) begin
            for (int c = 0; c < 250; c++) begin
                pulse_in = N'($urandom);
                rd_ready = ($urandom_range(0, 3) != 0);
                if (win == 2 && c == 100) begin
                    cfg_valid = 1'b1;
                    cfg_index = 2'd0;
                    cfg_delay = DB'($urandom_range(0, 20));
                end
                step();
                cfg_valid = 1'b0;
            end
            tick();
        end
        pulse_in = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
